// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: slice sizing, parameter
// legality and the layout of each stage register.
//
// Stage register k (k = 0 .. STAGES-1) holds:
//   a_q   : operand A, shifted right so the next unconsumed slice sits at bit 0
//   b_q   : effective operand B (already inverted for subtract), shifted the same way
//   s_q   : result slices produced so far, newest slice at the top, shifting down
//   c_q   : carry out of slice k, consumed by stage k+1 (cout at the last stage)
//   ovf_q : carry-into-MSB XOR carry-out of slice k (meaningful at the last stage)
//   v_q   : valid bit; 0 marks a bubble
package pipelined_adder_pkg;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_legal(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// One combinational slice of the ripple chain. c_msb is recovered from the
// MSB sum bit (sum = a ^ b ^ carry_in), which also works for a 1-bit slice.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb
);

    logic [SW:0] full;

    // Slice sum with carry out, and carry into the slice MSB
    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
        s     = full[SW-1:0];
        cout  = full[SW];
        c_msb = full[SW-1] ^ a[SW-1] ^ b[SW-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready flow control. The carry chain is
// cut into STAGES slices; a single global enable advances or holds the
// whole pipeline, so stalls propagate straight back to in_ready.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic en;

    // The pipeline moves only when the output slot is free or being drained
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src, b_src, s_src;
        logic             c_src, v_src;
        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic             c_q, ovf_q, v_q;
        logic [SLICE-1:0] sl_s;
        logic             sl_cout, sl_cmsb;

        if (k == 0) begin : g_first
            // Stage 0 takes operands straight from the ports, subtract folded in
            always_comb begin
                a_src = a;
                b_src = sub ? ~b : b;
                c_src = sub ? ~cin : cin;
                s_src = '0;
                v_src = in_valid;
            end
        end else begin : g_next
            // Later stages continue from the previous stage register
            always_comb begin
                a_src = g_stage[k-1].a_q;
                b_src = g_stage[k-1].b_q;
                c_src = g_stage[k-1].c_q;
                s_src = g_stage[k-1].s_q;
                v_src = g_stage[k-1].v_q;
            end
        end

        adder_slice #(.SW(SLICE)) u_slice (
            .a     (a_src[SLICE-1:0]),
            .b     (b_src[SLICE-1:0]),
            .cin   (c_src),
            .s     (sl_s),
            .cout  (sl_cout),
            .c_msb (sl_cmsb)
        );

        // Stage register: consume one operand slice, append one result slice
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
                v_q   <= 1'b0;
            end else if (en) begin
                a_q   <= a_src >> SLICE;
                b_q   <= b_src >> SLICE;
                s_q   <= WIDTH'({sl_s, s_src} >> SLICE);
                c_q   <= sl_cout;
                ovf_q <= sl_cmsb ^ sl_cout;
                v_q   <= v_src;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign s         = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int N_STG = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } op_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    op_t          stim_q[$];
    logic [W+1:0] exp_q[$];

    pipelined_adder #(.WIDTH(W), .STAGES(N_STG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {s, cout, ovf}; ovf from an explicit 31-bit carry into the MSB
    function automatic logic [W+1:0] ref_model(input op_t op);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = op.sub ? ~op.b : op.b;
        c0   = op.sub ? ~op.cin : op.cin;
        full = {1'b0, op.a} + {1'b0, bb} + {{W{1'b0}}, c0};
        low  = {1'b0, op.a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, c0};
        return {full[W-1:0], full[W], low[W-1] ^ full[W]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1 with an empty pipeline
    task automatic directed(input string tag, input op_t op, input logic [W-1:0] es,
                            input logic ec, input logic eo);
        a = op.a; b = op.b; cin = op.cin; sub = op.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < N_STG; i++) begin
            check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        check({tag, "_valid_at_latency"}, 64'(out_valid), 64'd1);
        check({tag, "_s"}, 64'(s), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk); #1;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    // Streams stim_q through the DUT; optional 5-cycle stall after 2nd result
    task automatic run_stream(input string tag, input bit do_stall, input int exp_cycles);
        int n, issued, got, cyc, stall_left;
        bit stall_done, held_ok, accept;
        logic [W+1:0] held;
        n = stim_q.size();
        issued = 0; got = 0; cyc = 0; stall_left = 0;
        stall_done = 0; held_ok = 0; held = '0;
        while (got < n && cyc < 3 * n + 50) begin
            out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
            if (issued < n) begin
                in_valid = 1'b1;
                a = stim_q[issued].a; b = stim_q[issued].b;
                cin = stim_q[issued].cin; sub = stim_q[issued].sub;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
                check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                if (held_ok)
                    check({tag, "_stall_hold"}, 64'({s, cout, ovf}), 64'(held));
                held = {s, cout, ovf};
                held_ok = 1;
                stall_left--;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_result"}, 64'd1, 64'd0);
                end else begin
                    check({tag, "_result"}, 64'({s, cout, ovf}), 64'(exp_q.pop_front()));
                end
                got++;
                if (do_stall && got == 2 && !stall_done) begin
                    stall_left = 5;
                    stall_done = 1;
                end
            end
            accept = in_valid && in_ready;
            if (accept) exp_q.push_back(ref_model(stim_q[issued]));
            @(posedge clk);
            if (accept) issued++;
            cyc++;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 64'(got), 64'(n));
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        check({tag, "_leftover"}, 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, "_no_dup"}, 64'(out_valid), 64'd0);
        end
        stim_q.delete();
        exp_q.delete();
    endtask

    initial begin
        op_t op;
        int  wait_cyc;

        // Asynchronous reset, observed before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        op = '{a: 32'd5, b: 32'hFFFF_FFFD, cin: 1'b0, sub: 1'b0};
        directed("add_carry", op, 32'h0000_0002, 1'b1, 1'b0);
        op = '{a: 32'h7FFF_FFFF, b: 32'd1, cin: 1'b0, sub: 1'b0};
        directed("signed_ovf", op, 32'h8000_0000, 1'b0, 1'b1);
        op = '{a: 32'hFFFF_FFFB, b: 32'd5, cin: 1'b0, sub: 1'b1};
        directed("sub", op, 32'hFFFF_FFF6, 1'b1, 1'b0);
        op = '{a: 32'hFFFF_FFFB, b: 32'd5, cin: 1'b1, sub: 1'b1};
        directed("sub_borrow", op, 32'hFFFF_FFF5, 1'b1, 1'b0);
        op = '{a: 32'h8000_0000, b: 32'd1, cin: 1'b0, sub: 1'b1};
        directed("sub_ovf", op, 32'h7FFF_FFFF, 1'b1, 1'b1);
        op = '{a: 32'hFFFF_FFFF, b: 32'd0, cin: 1'b1, sub: 1'b0};
        directed("wrap", op, 32'h0000_0000, 1'b1, 1'b0);

        // Back-to-back sweep: one result per cycle, latency 4
        for (int ia = -5; ia <= 5; ia++)
            for (int ib = -5; ib <= 5; ib++)
                for (int ic = 0; ic < 2; ic++)
                    for (int isb = 0; isb < 2; isb++)
                        stim_q.push_back('{a: 32'(ia), b: 32'(ib), cin: 1'(ic), sub: 1'(isb)});
        run_stream("sweep", 1'b0, 484 + N_STG);

        // Burst of 8 with a 5-cycle consumer stall after the 2nd result
        for (int i = 0; i < 8; i++)
            stim_q.push_back('{a: 32'h1000_0000 * 32'(i) + 32'(i), b: 32'h0FFF_FFF0 + 32'(3 * i),
                               cin: 1'(i & 1), sub: 1'((i >> 1) & 1)});
        run_stream("backpressure", 1'b1, 8 + N_STG + 5);

        // Reset with three operations in flight and a result waiting
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'(100 + i); b = 32'(7 * i); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 10) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("rstmid_result_pending", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid_drop", 64'(out_valid), 64'd0);
        check("rstmid_s_clear", 64'(s), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rstmid_no_stale", 64'(out_valid), 64'd0);
        end
        op = '{a: 32'd1234, b: 32'd4321, cin: 1'b1, sub: 1'b0};
        directed("post_reset", op, 32'd5556, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
